// File: rtl/ptw_mem_arb.sv
// Arbitrates page-table-walk reads and PTE accessed/dirty read-modify-writes
// onto a single memory port, with a response timeout.
module ptw_mem_arb #(
   parameter int PA_W    = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            walk_req_valid,
   input  logic [PA_W-1:0] walk_req_addr,
   output logic            walk_rsp_valid,
   output logic [63:0]     walk_rsp_data,
   output logic [127:0]    walk_rsp_cacheline,
   input  logic            mark_valid,
   input  logic            mark_accessed,
   input  logic            mark_dirty,
   input  logic [63:0]     mark_addr,
   output logic            mark_rsp_valid,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [PA_W-1:0] mem_req_addr,
   output logic            mem_req_store,
   output logic [63:0]     mem_req_data,
   input  logic            mem_rsp_valid,
   input  logic [63:0]     mem_rsp_data,
   input  logic [127:0]    mem_rsp_cacheline,
   output logic            busy,
   output logic            timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, WALK_REQ, WALK_WAIT, MRD_REQ, MRD_WAIT, MWR_REQ, MWR_WAIT
   } state_t;

   state_t          state, state_nxt;
   logic            walk_pend, mark_pend;
   logic [PA_W-1:0] walk_addr_q, mark_addr_q;
   logic            acc_q, dirty_q;
   logic            rr_mark;       // mark wins the next contended arbitration
   logic [CW-1:0]   wait_cnt;
   logic [63:0]     mark_new;
   logic            grant_walk, grant_mark, timed_out;
   logic            walk_svc, mark_svc, in_req, in_wait;

   if (PA_W < 64) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^mark_addr[63:PA_W];
   end

   assign walk_svc      = (state == WALK_REQ) || (state == WALK_WAIT);
   assign mark_svc      = (state == MRD_REQ) || (state == MRD_WAIT) ||
                          (state == MWR_REQ) || (state == MWR_WAIT);
   assign in_req        = (state == WALK_REQ) || (state == MRD_REQ) || (state == MWR_REQ);
   assign in_wait       = (state == WALK_WAIT) || (state == MRD_WAIT) || (state == MWR_WAIT);
   assign mem_req_valid = in_req;
   assign busy          = (state != IDLE) || walk_pend || mark_pend;

   always_comb begin
      state_nxt  = state;
      grant_walk = 1'b0;
      grant_mark = 1'b0;
      mark_new   = mem_rsp_data | {56'd0, dirty_q, acc_q | dirty_q, 6'd0};
      timed_out  = in_wait && !mem_rsp_valid && (wait_cnt == CW'(TIMEOUT - 1));
      case (state)
         IDLE: begin
            if (walk_pend && (!mark_pend || !rr_mark)) begin
               grant_walk = 1'b1;
               state_nxt  = WALK_REQ;
            end else if (mark_pend) begin
               grant_mark = 1'b1;
               state_nxt  = MRD_REQ;
            end
         end
         WALK_REQ:  if (mem_req_ready) state_nxt = WALK_WAIT;
         WALK_WAIT: if (mem_rsp_valid || timed_out) state_nxt = IDLE;
         MRD_REQ:   if (mem_req_ready) state_nxt = MRD_WAIT;
         MRD_WAIT: begin
            if (mem_rsp_valid)  state_nxt = (mark_new == mem_rsp_data) ? IDLE : MWR_REQ;
            else if (timed_out) state_nxt = IDLE;
         end
         MWR_REQ:   if (mem_req_ready) state_nxt = MWR_WAIT;
         MWR_WAIT:  if (mem_rsp_valid || timed_out) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         walk_pend          <= 1'b0;
         mark_pend          <= 1'b0;
         walk_addr_q        <= '0;
         mark_addr_q        <= '0;
         acc_q              <= 1'b0;
         dirty_q            <= 1'b0;
         rr_mark            <= 1'b0;
         wait_cnt           <= '0;
         walk_rsp_valid     <= 1'b0;
         walk_rsp_data      <= '0;
         walk_rsp_cacheline <= '0;
         mark_rsp_valid     <= 1'b0;
         mem_req_addr       <= '0;
         mem_req_store      <= 1'b0;
         mem_req_data       <= '0;
         timeout_err        <= 1'b0;
      end else begin
         walk_rsp_valid <= 1'b0;
         mark_rsp_valid <= 1'b0;

         if (walk_req_valid && !walk_pend && !walk_svc) begin
            walk_pend   <= 1'b1;
            walk_addr_q <= walk_req_addr & ~PA_W'(7);
         end
         if (mark_valid && !mark_pend && !mark_svc) begin
            mark_pend   <= 1'b1;
            mark_addr_q <= mark_addr[PA_W-1:0] & ~PA_W'(7);
            acc_q       <= mark_accessed;
            dirty_q     <= mark_dirty;
         end

         // Pointer only moves when both requesters actually competed.
         if (grant_walk) begin
            walk_pend     <= 1'b0;
            mem_req_addr  <= walk_addr_q;
            mem_req_store <= 1'b0;
            mem_req_data  <= '0;
            if (mark_pend) rr_mark <= 1'b1;
         end
         if (grant_mark) begin
            mark_pend     <= 1'b0;
            mem_req_addr  <= mark_addr_q;
            mem_req_store <= 1'b0;
            mem_req_data  <= '0;
            if (walk_pend) rr_mark <= 1'b0;
         end

         if (in_req)       wait_cnt <= '0;
         else if (in_wait) wait_cnt <= wait_cnt + 1'b1;

         case (state)
            WALK_WAIT: begin
               if (mem_rsp_valid) begin
                  walk_rsp_valid     <= 1'b1;
                  walk_rsp_data      <= mem_rsp_data;
                  walk_rsp_cacheline <= mem_rsp_cacheline;
               end else if (timed_out) begin
                  walk_rsp_valid     <= 1'b1;
                  walk_rsp_data      <= '0;
                  walk_rsp_cacheline <= '0;
                  timeout_err        <= 1'b1;
               end
            end
            MRD_WAIT: begin
               if (mem_rsp_valid) begin
                  if (mark_new == mem_rsp_data) begin
                     mark_rsp_valid <= 1'b1;
                  end else begin
                     mem_req_store <= 1'b1;
                     mem_req_data  <= mark_new;
                  end
               end else if (timed_out) begin
                  mark_rsp_valid <= 1'b1;
                  timeout_err    <= 1'b1;
               end
            end
            MWR_WAIT: begin
               if (mem_rsp_valid || timed_out) mark_rsp_valid <= 1'b1;
               if (timed_out)                  timeout_err    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ptw_mem_arb.sv
// Self-checking bench for ptw_mem_arb: behavioural memory/responder plus
// per-scenario tasks comparing against expectations derived from PTE rules.
module tb_ptw_mem_arb;
   localparam int PA_W = 32;
   localparam int TMO  = 16;

   logic         clk = 1'b0, reset = 1'b1;
   logic         walk_req_valid = 1'b0;
   logic [31:0]  walk_req_addr = '0;
   logic         walk_rsp_valid;
   logic [63:0]  walk_rsp_data;
   logic [127:0] walk_rsp_cacheline;
   logic         mark_valid = 1'b0, mark_accessed = 1'b0, mark_dirty = 1'b0;
   logic [63:0]  mark_addr = '0;
   logic         mark_rsp_valid;
   logic         mem_req_valid;
   logic         mem_req_ready = 1'b0;
   logic [31:0]  mem_req_addr;
   logic         mem_req_store;
   logic [63:0]  mem_req_data;
   logic         mem_rsp_valid = 1'b0;
   logic [63:0]  mem_rsp_data = '0;
   logic [127:0] mem_rsp_cacheline = '0;
   logic         busy, timeout_err;

   ptw_mem_arb #(.PA_W(PA_W), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .walk_req_valid(walk_req_valid), .walk_req_addr(walk_req_addr),
      .walk_rsp_valid(walk_rsp_valid), .walk_rsp_data(walk_rsp_data),
      .walk_rsp_cacheline(walk_rsp_cacheline),
      .mark_valid(mark_valid), .mark_accessed(mark_accessed), .mark_dirty(mark_dirty),
      .mark_addr(mark_addr), .mark_rsp_valid(mark_rsp_valid),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_store(mem_req_store), .mem_req_data(mem_req_data),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_cacheline(mem_rsp_cacheline),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents; unwritten words read back as an address-derived pattern.
   logic [63:0] mem [logic [31:0]];
   function automatic logic [63:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a ^ 32'h5a5a_0000, ~a};
   endfunction
   function automatic logic [127:0] cl_of(input logic [63:0] d);
      return {~d, d ^ 64'h0123_4567_89ab_cdef};
   endfunction

   // Responder controls and logs
   int          ready_mode = 0;   // 0 always ready, 1 random, 2 never
   int          lat = 2;
   bit          drop = 0, stray = 0;
   int          cnt = 0, rsp_cyc = -1;
   logic [31:0] p_addr;
   logic        p_store;
   logic [63:0] p_data;
   logic [31:0]  rq_addr[$];
   bit           rq_store[$];
   logic [63:0]  rq_data[$];
   int           rq_cyc[$];
   logic [63:0]  wq_data[$];
   logic [127:0] wq_cl[$];
   int           wq_cyc[$], mq_cyc[$];

   initial begin : responder
      forever begin
         @(negedge clk);
         if (walk_rsp_valid) begin
            wq_data.push_back(walk_rsp_data);
            wq_cl.push_back(walk_rsp_cacheline);
            wq_cyc.push_back(cyc);
         end
         if (mark_rsp_valid) mq_cyc.push_back(cyc);
         mem_rsp_valid     = 1'b0;
         mem_rsp_data      = {$urandom, $urandom};
         mem_rsp_cacheline = {$urandom, $urandom, $urandom, $urandom};
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mem_rsp_valid = 1'b1;
               rsp_cyc       = cyc;
               if (p_store) mem[p_addr] = p_data;
               else begin
                  mem_rsp_data      = mem_rd(p_addr);
                  mem_rsp_cacheline = cl_of(mem_rsp_data);
               end
            end
         end else if (stray) begin
            mem_rsp_valid = 1'b1;
            stray         = 0;
         end
         case (ready_mode)
            0:       mem_req_ready = 1'b1;
            1:       mem_req_ready = 1'($urandom_range(0, 1));
            default: mem_req_ready = 1'b0;
         endcase
         if (mem_req_valid && mem_req_ready) begin
            rq_addr.push_back(mem_req_addr);
            rq_store.push_back(mem_req_store);
            rq_data.push_back(mem_req_data);
            rq_cyc.push_back(cyc);
            if (!drop) begin
               cnt = lat; p_addr = mem_req_addr; p_store = mem_req_store; p_data = mem_req_data;
            end
         end
      end
   end

   task automatic clear_logs();
      rq_addr.delete(); rq_store.delete(); rq_data.delete(); rq_cyc.delete();
      wq_data.delete(); wq_cl.delete(); wq_cyc.delete(); mq_cyc.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
   endtask

   task automatic pulse_walk(input logic [31:0] a);
      walk_req_addr = a; walk_req_valid = 1'b1;
      @(posedge clk); #1;
      walk_req_valid = 1'b0;
   endtask

   task automatic pulse_mark(input logic [63:0] a, input bit acc, input bit dty);
      mark_addr = a; mark_accessed = acc; mark_dirty = dty; mark_valid = 1'b1;
      @(posedge clk); #1;
      mark_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while ((busy || walk_rsp_valid || mark_rsp_valid) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n >= 200) begin errors++; $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", nm, busy, n); end
   endtask

   task automatic test_reset();
      reset = 1'b1; walk_req_valid = 1'b1; mark_valid = 1'b1; mark_dirty = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if ({mem_req_valid, walk_rsp_valid, mark_rsp_valid, busy, timeout_err, mem_req_store} !== 6'b0) begin
         errors++; $display("FAIL reset_flags: %b required 000000",
            {mem_req_valid, walk_rsp_valid, mark_rsp_valid, busy, timeout_err, mem_req_store});
      end
      checks++;
      if ({mem_req_addr, mem_req_data, walk_rsp_data} !== '0) begin
         errors++; $display("FAIL reset_data: addr %h data %h wdata %h required 0", mem_req_addr, mem_req_data, walk_rsp_data);
      end
      walk_req_valid = 1'b0; mark_valid = 1'b0; mark_dirty = 1'b0; reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_pulse_ignored: busy %b required 0", busy); end
   endtask

   task automatic test_walk_latency();
      int t;
      clear_logs(); ready_mode = 0; lat = 2; mem[32'h1000] = 64'h2001;
      t = cyc;
      pulse_walk(32'h1004);
      wait_done("walk");
      checks++;
      if (rq_addr.size() != 1 || rq_cyc[0] != t + 2 || rq_addr[0] !== 32'h1000 || rq_store[0] !== 1'b0) begin
         errors++; $display("FAIL walk_req: n=%0d cyc %0d addr %h store %b required n=1 cyc %0d addr 00001000 store 0",
            rq_addr.size(), rq_cyc.size() ? rq_cyc[0] : -1, mem_req_addr, mem_req_store, t + 2);
      end
      checks++;
      if (wq_data.size() != 1 || wq_data[0] !== 64'h2001 || wq_cl[0] !== cl_of(64'h2001)) begin
         errors++; $display("FAIL walk_data: n=%0d data %h required n=1 data 2001", wq_data.size(), walk_rsp_data);
      end
      checks++;
      if (wq_cyc.size() != 1 || wq_cyc[0] != rsp_cyc + 1) begin
         errors++; $display("FAIL walk_rsp_timing: rsp cyc %0d required %0d", wq_cyc.size() ? wq_cyc[0] : -1, rsp_cyc + 1);
      end
   endtask

   task automatic test_mark_nowrite();
      clear_logs(); lat = 3; mem[32'h2008] = 64'h41;
      pulse_mark(64'h2008, 1'b1, 1'b0);
      wait_done("mark_nowrite");
      checks++;
      if (rq_addr.size() != 1 || rq_store[0] !== 1'b0 || rq_addr[0] !== 32'h2008) begin
         errors++; $display("FAIL mark_nowrite_reqs: %0d requests required 1 read of 00002008", rq_addr.size());
      end
      checks++;
      if (mq_cyc.size() != 1 || mq_cyc[0] != rsp_cyc + 1 || wq_data.size() != 0) begin
         errors++; $display("FAIL mark_nowrite_rsp: n=%0d cyc %0d required n=1 cyc %0d", mq_cyc.size(),
            mq_cyc.size() ? mq_cyc[0] : -1, rsp_cyc + 1);
      end
   endtask

   task automatic test_mark_write();
      clear_logs(); lat = 1; mem[32'h3008] = 64'h01;
      pulse_mark(64'h300C, 1'b0, 1'b1);
      wait_done("mark_write");
      checks++;
      if (rq_addr.size() != 2 || rq_store[1] !== 1'b1 || rq_data[1] !== 64'hC1 || rq_addr[1] !== 32'h3008) begin
         errors++; $display("FAIL mark_write_req: n=%0d data %h required n=2 store of c1 to 00003008",
            rq_addr.size(), rq_data.size() > 1 ? rq_data[1] : 64'h0);
      end
      checks++;
      if (mq_cyc.size() != 1 || mq_cyc[0] != rsp_cyc + 1 || mem_rd(32'h3008) !== 64'hC1) begin
         errors++; $display("FAIL mark_write_rsp: n=%0d mem %h required n=1 at cyc %0d mem c1",
            mq_cyc.size(), mem_rd(32'h3008), rsp_cyc + 1);
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_order [4];
      do_reset(); clear_logs(); lat = 1; mem[32'h5000] = 64'h40;
      exp_order = '{32'h4000, 32'h5000, 32'h5000, 32'h4000};
      for (int r = 0; r < 2; r++) begin
         walk_req_addr = 32'h4000; mark_addr = 64'h5000; mark_accessed = 1'b1; mark_dirty = 1'b0;
         walk_req_valid = 1'b1; mark_valid = 1'b1;
         @(posedge clk); #1;
         walk_req_valid = 1'b0; mark_valid = 1'b0;
         wait_done("rr");
      end
      checks++;
      if (rq_addr.size() != 4) begin
         errors++; $display("FAIL rr_count: %0d requests required 4", rq_addr.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (rq_addr[k] !== exp_order[k]) begin
               errors++; $display("FAIL rr_order[%0d]: addr %h required %h", k, rq_addr[k], exp_order[k]);
            end
         end
      end
   endtask

   task automatic test_ready_stall();
      logic [31:0] a0; logic [63:0] d0; logic s0; int n = 0;
      clear_logs(); ready_mode = 2; lat = 1; mem[32'h6000] = 64'h0;
      pulse_mark(64'h6000, 1'b0, 1'b1);
      while (!mem_req_valid && n < 20) begin @(posedge clk); #1; n++; end
      a0 = mem_req_addr; d0 = mem_req_data; s0 = mem_req_store;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== a0 || mem_req_data !== d0 || mem_req_store !== s0 || a0 !== 32'h6000) begin
            errors++; $display("FAIL stall[%0d]: valid %b addr %h data %h required 1 %h %h", k,
               mem_req_valid, mem_req_addr, mem_req_data, 32'h6000, d0);
         end
      end
      ready_mode = 0;
      wait_done("stall");
      checks++;
      if (rq_addr.size() != 2 || mem_rd(32'h6000) !== 64'hC0 || mq_cyc.size() != 1) begin
         errors++; $display("FAIL stall_finish: n=%0d mem %h required 2 requests, mem c0", rq_addr.size(), mem_rd(32'h6000));
      end
   endtask

   task automatic test_timeout();
      clear_logs(); drop = 1; ready_mode = 0;
      pulse_walk(32'h7000);
      wait_done("tmo_walk");
      checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL tmo_flag: timeout_err %b busy %b required 1 0", timeout_err, busy);
      end
      checks++;
      if (wq_data.size() != 1 || wq_data[0] !== 64'h0 || wq_cl[0] !== 128'h0 || wq_cyc[0] != rq_cyc[0] + TMO + 1) begin
         errors++; $display("FAIL tmo_walk_rsp: n=%0d data %h cyc %0d required n=1 data 0 cyc %0d", wq_data.size(),
            walk_rsp_data, wq_cyc.size() ? wq_cyc[0] : -1, rq_cyc.size() ? rq_cyc[0] + TMO + 1 : -1);
      end
      pulse_mark(64'h7008, 1'b0, 1'b1);
      wait_done("tmo_mark");
      checks++;
      if (rq_addr.size() != 2 || rq_store[1] !== 1'b0 || mq_cyc.size() != 1) begin
         errors++; $display("FAIL tmo_mark: %0d requests %0d mark rsps required 2 reads 1 rsp", rq_addr.size(), mq_cyc.size());
      end
      drop = 0;
      do_reset();
      checks++;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_reset_clear: timeout_err %b required 0", timeout_err); end
   endtask

   task automatic test_reset_abandon();
      int n = 0;
      clear_logs(); stray = 1;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (wq_data.size() != 0 || mq_cyc.size() != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL stray_rsp: walk %0d mark %0d busy %b required 0 0 0", wq_data.size(), mq_cyc.size(), busy);
      end
      lat = 6;
      pulse_walk(32'h8000);
      while (rq_addr.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      checks++;
      if (wq_data.size() != 0 || busy !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++; $display("FAIL reset_abandon: walk rsps %0d busy %b required 0 0", wq_data.size(), busy);
      end
      lat = 2;
      pulse_walk(32'h8010);
      wait_done("after_abandon");
      checks++;
      if (wq_data.size() != 1 || wq_data[0] !== mem_rd(32'h8010)) begin
         errors++; $display("FAIL after_abandon: n=%0d data %h required n=1 data %h", wq_data.size(), walk_rsp_data, mem_rd(32'h8010));
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      clear_logs(); lat = 1;
      pulse_walk(32'h9000);
      while (!walk_rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      pulse_walk(32'h9010);
      wait_done("b2b");
      checks++;
      if (wq_data.size() != 2 || rq_addr.size() != 2 || rq_addr[1] !== 32'h9010 || wq_data[1] !== mem_rd(32'h9010)) begin
         errors++; $display("FAIL back_to_back: %0d rsps %0d reqs required 2 2 second addr 00009010", wq_data.size(), rq_addr.size());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, al;
         logic [63:0] d, nw;
         bit acc, dty;
         a  = 32'hA000 + 32'($urandom_range(0, 15)) * 8 + 32'($urandom_range(0, 7));
         al = a & ~32'h7;
         if ($urandom_range(0, 1) == 1)
            mem[al] = ({$urandom, $urandom} & ~64'hC0) | (64'($urandom_range(0, 3)) << 6);
         lat = $urandom_range(1, 4); ready_mode = 1; clear_logs();
         d = mem_rd(al);
         if ($urandom_range(0, 1) == 1) begin
            pulse_walk(a);
            wait_done("rand_walk");
            checks++;
            if (wq_data.size() != 1 || wq_data[0] !== d || wq_cl[0] !== cl_of(d) || rq_addr.size() != 1 || rq_addr[0] !== al) begin
               errors++; $display("FAIL rand_walk[%0d]: n=%0d data %h required n=1 data %h addr %h", i,
                  wq_data.size(), walk_rsp_data, d, al);
            end
         end else begin
            acc = 1'($urandom_range(0, 1)); dty = 1'($urandom_range(0, 1));
            nw  = d | (dty ? 64'hC0 : (acc ? 64'h40 : 64'h0));
            pulse_mark({$urandom, a}, acc, dty);
            wait_done("rand_mark");
            checks++;
            if (mq_cyc.size() != 1 || rq_addr.size() != ((nw != d) ? 2 : 1) || mem_rd(al) !== nw) begin
               errors++; $display("FAIL rand_mark[%0d]: rsps %0d reqs %0d mem %h required 1 %0d %h", i,
                  mq_cyc.size(), rq_addr.size(), mem_rd(al), (nw != d) ? 2 : 1, nw);
            end
            checks++;
            if (rq_addr.size() == 0 || rq_addr[0] !== al || rq_store[0] !== 1'b0) begin
               errors++; $display("FAIL rand_mark_addr[%0d]: addr %h required read of %h", i,
                  rq_addr.size() ? rq_addr[0] : 32'h0, al);
            end
         end
      end
      ready_mode = 0;
   endtask

   initial begin
      test_reset();
      test_walk_latency();
      test_mark_nowrite();
      test_mark_write();
      test_round_robin();
      test_ready_stall();
      test_timeout();
      test_reset_abandon();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
